// File: rtl/tft_pix_prefetch.sv
// Pixel prefetch FIFO ahead of the TFT timing controller; pix_data lags data_req by one cycle.
// Memory bursts are requested only when a whole burst fits; an empty FIFO returns zero and latches underflow.
module tft_pix_prefetch #(
    parameter int                DEPTH     = 512,
    parameter int                AW        = 9,
    parameter int                BURST_LEN = 64,
    parameter int                FRAME_PIX = 384000,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_33m,
    input  logic              sys_rst_n,
    input  logic              vsync,
    input  logic              data_req,
    output logic [15:0]       pix_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [15:0]       rd_data,
    input  logic              rd_valid,
    output logic [AW:0]       fifo_level,
    output logic              underflow
);
    localparam int CW = $clog2(FRAME_PIX + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [AW:0]       LVL_LIM   = (AW+1)'(DEPTH - BURST_LEN);
    localparam logic [AW:0]       LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]     FRAME_END = CW'(FRAME_PIX);
    localparam logic [CW-1:0]     CNT_STEP  = CW'(BURST_LEN);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN, S_FLUSH} state_t;

    state_t            r_state;
    logic              r_vs_q;
    logic              r_vs_qq;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [CW-1:0]     r_req_cnt;
    logic [BW-1:0]     r_beat;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [15:0]       r_pix;
    logic              r_underflow;
    logic [15:0]       r_mem [DEPTH];

    logic w_frame_start;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_frame_start = r_vs_q & ~r_vs_qq;
    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == LVL_FULL);
    assign w_pop         = data_req & ~w_empty;
    // The beat that coincides with a frame start belongs to the stale frame.
    assign w_push        = rd_valid & (r_state == S_RECV) & ~w_frame_start & ~w_full;

    always_ff @(posedge clk_33m) begin
        if (sys_rst_n && w_push)
            r_mem[r_wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk_33m) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_vs_q      <= 1'b0;
            r_vs_qq     <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= BASE_ADDR;
            r_req_cnt   <= '0;
            r_beat      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pix       <= 16'h0000;
            r_underflow <= 1'b0;
        end else begin
            r_vs_q  <= vsync;
            r_vs_qq <= r_vs_q;

            r_pix <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (data_req && w_empty)
                r_underflow <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_level <= r_level + {AW'(0), w_push} - {AW'(0), w_pop};

            // FLUSH is last so its clears override the FIFO updates above.
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= S_FLUSH;
                    end else if (r_level <= LVL_LIM && r_req_cnt < FRAME_END) begin
                        r_rd_req <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_beat   <= '0;
                        r_state  <= w_frame_start ? S_DRAIN : S_RECV;
                    end else if (w_frame_start) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_FLUSH;
                    end
                end
                S_RECV: begin
                    if (rd_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_rd_addr <= r_rd_addr + ADDR_STEP;
                            r_req_cnt <= r_req_cnt + CNT_STEP;
                            r_state   <= w_frame_start ? S_FLUSH : S_IDLE;
                        end else if (w_frame_start) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_frame_start) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rd_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT)
                            r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_wr_ptr    <= '0;
                    r_rd_ptr    <= '0;
                    r_level     <= '0;
                    r_rd_addr   <= BASE_ADDR;
                    r_req_cnt   <= '0;
                    r_underflow <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_data   = r_pix;
    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign fifo_level = r_level;
    assign underflow  = r_underflow;
endmodule

// File: tb/tb_tft_pix_prefetch.sv
// Bench for tft_pix_prefetch with a 640-pixel frame so both the space limit and the frame end are reachable.
module tb_tft_pix_prefetch;
    logic        clk_33m = 1'b0;
    logic        sys_rst_n;
    logic        vsync;
    logic        data_req;
    logic [15:0] pix_data;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [9:0]  fifo_level;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    tft_pix_prefetch #(.FRAME_PIX(640)) dut (
        .clk_33m(clk_33m), .sys_rst_n(sys_rst_n), .vsync(vsync), .data_req(data_req),
        .pix_data(pix_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level), .underflow(underflow)
    );

    always #5 clk_33m = ~clk_33m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel scoreboard: every data_req cycle owes one pix_data value on the following cycle.
    initial begin
        logic        mon_req;
        logic [15:0] e;
        forever begin
            @(posedge clk_33m);
            mon_req = data_req;
            @(negedge clk_33m);
            if (mon_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: got %0h expected none", pix_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix", {16'h0, pix_data}, {16'h0, e});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk_33m);
        #1;
    endtask

    task automatic pop_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            data_req = 1'b1;
            exp_q.push_back(16'(first + i));
            step();
        end
        data_req = 1'b0;
    endtask

    // Serve one burst; stop_at raises vsync at that beat, npop pops alongside the first beats.
    task automatic burst(input int addr, input int stop_at, input int npop, input int first);
        int t;
        t = 0;
        @(negedge clk_33m);
        while (!rd_req && t < 200) begin
            @(negedge clk_33m);
            t++;
        end
        chk("rd_req_seen", {31'h0, rd_req}, 32'h1);
        chk("rd_addr", {8'h0, rd_addr}, 32'(addr));
        if (!rd_req) return;
        step();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_valid = 1'b1;
            rd_data  = 16'(addr + i + 1);
            if (i == stop_at) vsync = 1'b1;
            if (i == stop_at + 20) vsync = 1'b0;
            if (i < npop) begin
                data_req = 1'b1;
                exp_q.push_back(16'(first + i));
            end else begin
                data_req = 1'b0;
            end
            @(negedge clk_33m);
            if (i == 0) chk("rd_req_drop", {31'h0, rd_req}, 32'h0);
            if (i <= npop && npop > 0) chk("level_pushpop", {22'h0, fifo_level}, 32'd5);
            if (stop_at >= 0 && i == 40)
                chk("drain_level_range", {31'h0, (fifo_level >= 10 && fifo_level <= 12)}, 32'h1);
            step();
        end
        rd_valid = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        logic seen;
        int   t;
        sys_rst_n = 1'b0; vsync = 1'b0; data_req = 1'b0;
        rd_ack = 1'b0; rd_data = 16'h0; rd_valid = 1'b0;
        repeat (3) step();
        @(negedge clk_33m);
        chk("rst_rd_req", {31'h0, rd_req}, 32'h0);
        chk("rst_rd_addr", {8'h0, rd_addr}, 32'h0);
        chk("rst_level", {22'h0, fifo_level}, 32'h0);
        chk("rst_underflow", {31'h0, underflow}, 32'h0);
        chk("rst_pix", {16'h0, pix_data}, 32'h0);

        step();
        sys_rst_n = 1'b1;
        t = 0;
        @(negedge clk_33m);
        while (!rd_req && t < 2) begin
            @(negedge clk_33m);
            t++;
        end
        chk("req_after_reset", {31'h0, rd_req}, 32'h1);

        // Fill to capacity: eight bursts, level grows by 64 each.
        for (int k = 0; k < 8; k++) begin
            burst(k * 64, -1, 0, 0);
            @(negedge clk_33m);
            chk("fill_level", {22'h0, fifo_level}, 32'((k + 1) * 64));
            step();
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_33m);
            seen |= rd_req;
        end
        chk("no_req_when_full", {31'h0, seen}, 32'h0);
        step();

        pop_n(64, 1);
        @(negedge clk_33m);
        chk("level_after_pop64", {22'h0, fifo_level}, 32'd448);
        chk("no_underflow", {31'h0, underflow}, 32'h0);
        burst(512, -1, 0, 0);
        step();
        pop_n(64, 65);
        burst(576, -1, 0, 0);
        @(negedge clk_33m);
        chk("level_refill", {22'h0, fifo_level}, 32'd512);
        step();

        // Frame end: space frees up but all 640 pixels were already requested.
        pop_n(448, 129);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_33m);
            seen |= rd_req;
        end
        chk("no_req_frame_end", {31'h0, seen}, 32'h0);
        chk("level_frame_end", {22'h0, fifo_level}, 32'd64);
        step();
        pop_n(64, 577);

        pop_n(1, 0);
        @(negedge clk_33m);
        chk("underflow_set", {31'h0, underflow}, 32'h1);
        chk("level_empty", {22'h0, fifo_level}, 32'h0);
        repeat (5) step();
        @(negedge clk_33m);
        chk("underflow_sticky", {31'h0, underflow}, 32'h1);

        step();
        vsync = 1'b1;
        @(negedge clk_33m);
        @(negedge clk_33m);
        @(negedge clk_33m);
        chk("underflow_before_flush", {31'h0, underflow}, 32'h1);
        @(negedge clk_33m);
        chk("underflow_cleared", {31'h0, underflow}, 32'h0);
        step();
        vsync = 1'b0;

        // vsync rises after 10 beats: rest of the burst is drained, then flushed.
        burst(0, 10, 0, 0);
        @(negedge clk_33m);
        @(negedge clk_33m);
        chk("level_after_drain_flush", {22'h0, fifo_level}, 32'h0);
        chk("underflow_after_flush", {31'h0, underflow}, 32'h0);
        step();

        burst(0, -1, 0, 0);
        pop_n(59, 1);
        @(negedge clk_33m);
        chk("level_five", {22'h0, fifo_level}, 32'd5);
        step();
        burst(64, -1, 5, 60);
        @(negedge clk_33m);
        chk("level_after_pushpop", {22'h0, fifo_level}, 32'd64);
        step();
        pop_n(64, 65);
        repeat (3) step();
        @(negedge clk_33m);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tft_pix_prefetch.md
Name: tft_pix_prefetch

Overview:
- Single-clock pixel prefetch buffer directly upstream of the TFT timing controller.
- Fetches the current frame from frame memory in fixed-length bursts through a request/ack/valid read port and stores the pixels in an internal FIFO.
- Returns one RGB565 pixel on pix_data one cycle after each data_req from the TFT controller.
- Restarts at the frame base address on every rising edge of vsync.

Parameters:
- DEPTH, 512: FIFO depth in 16-bit words; power of two.
- AW, 9: FIFO pointer width; log2(DEPTH).
- BURST_LEN, 64: words per memory read burst; BURST_LEN <= DEPTH.
- FRAME_PIX, 384000: pixels per frame (800x480); integer multiple of BURST_LEN.
- ADDR_W, 24: memory word-address width.
- BASE_ADDR, 24'd0: word address of pixel 0 of the frame.

Ports:
- clk_33m  input  1  pixel clock; the only clock.
- sys_rst_n  input  1  synchronous active-low reset.
- vsync  input  1  frame sync from the TFT controller; active high.
- data_req  input  1  pixel request from the TFT controller.
- pix_data  output  16  pixel to the TFT controller data_in; valid the cycle after data_req.
- rd_req  output  1  burst read request to the memory arbiter.
- rd_addr  output  ADDR_W  burst start word address; stable while rd_req=1.
- rd_ack  input  1  arbiter accepts the burst; one-cycle pulse.
- rd_data  input  16  read data beat.
- rd_valid  input  1  rd_data is valid this cycle.
- fifo_level  output  AW+1  current FIFO occupancy.
- underflow  output  1  sticky; set on data_req while the FIFO is empty.

Behaviour:
- Reset (sampled on posedge clk_33m with sys_rst_n=0):
  - pix_data=0, rd_req=0, rd_addr=BASE_ADDR, fifo_level=0, underflow=0.
  - Pointers cleared, requested-pixel counter=0, FSM=IDLE.
- vsync edge detect: vsync is registered once; a frame start is a 0->1 transition of the registered copy.
- FSM states: IDLE, REQ, RECV, DRAIN, FLUSH.
  - IDLE -> REQ when free space (DEPTH - fifo_level) >= BURST_LEN and requested-pixel counter < FRAME_PIX.
  - REQ: rd_req=1 with rd_addr held. On rd_ack: rd_req drops the next cycle, beat counter cleared, go to RECV.
  - RECV: each rd_valid beat is written to the FIFO and the beat counter increments. After beat BURST_LEN:
    - rd_addr += BURST_LEN;
    - requested-pixel counter += BURST_LEN;
    - return to IDLE.
  - Frame start while in IDLE or REQ (before rd_ack): rd_req drops next cycle, go to FLUSH.
  - Frame start while in RECV, or in REQ in the same cycle as rd_ack: go to DRAIN. DRAIN discards the remaining rd_valid beats of the burst (counts them, writes none), then goes to FLUSH.
  - FLUSH (one cycle): pointers cleared, fifo_level=0, rd_addr=BASE_ADDR, requested-pixel counter=0, underflow=0; go to IDLE.
- Read side:
  - data_req=1 and FIFO non-empty: pop; pix_data <= head word at the next edge.
  - data_req=1 and FIFO empty: pix_data <= 16'h0000, underflow <= 1, pointers unchanged.
  - data_req=0: pix_data <= 16'h0000.
- Simultaneous push and pop: fifo_level unchanged; an empty FIFO with a push and data_req in the same cycle counts as underflow (no write-through).
- FIFO full: cannot occur, because a burst is requested only when there is room. A rd_valid beat arriving with the FIFO full is dropped and underflow is not affected.
- rd_valid outside RECV/DRAIN is ignored.
- Frame end: once requested-pixel counter = FRAME_PIX, no further requests are made until the next flush.
- Reset mid-burst returns to the reset state immediately. The arbiter is expected to abort the burst on the same reset.

Test Plan:
- Reset then idle memory: rd_req rises within 2 cycles with rd_addr=0. Ack with 64 beats: fifo_level=64, next rd_req with rd_addr=64. Requests continue until fifo_level reaches 512.
- FIFO preloaded 0x0001..0x0040, data_req held for 64 cycles: pix_data=0x0001..0x0040 in order, each one cycle after its request; underflow stays 0.
- data_req on an empty FIFO: the next-cycle pix_data=0x0000 and underflow=1; underflow stays 1 until the next vsync rising edge, and clears on the FLUSH cycle.
- vsync rises after 10 of 64 beats of a burst: the remaining 54 beats are not written; fifo_level=0 after FLUSH; the next rd_addr=0.
- Full frame with FRAME_PIX=256, BURST_LEN=64 and continuous data_req: exactly 4 bursts at addresses 0, 64, 128, 192; no 5th rd_req before vsync.
- Push and pop in the same cycle at fifo_level=5: fifo_level stays 5 and pix_data is the oldest word.
